axi4lite_burst_bridge: RTL and testbench

Parametrised AXI4 (burst, ID-tagged) slave to AXI4-Lite master bridge, placed between the CPU/debug AXI4 fabric and the AXI4-Lite peripheral bus. Splits FIXED/INCR/WRAP bursts of up to 256 beats into single Lite transactions, one outstanding beat per channel. The Lite-side AW and W handshakes are fully decoupled, so the slave may assert AWREADY and WREADY in any order. Burst-level B and R responses are returned with the captured ID.

---
 rtl/axi4lite_burst_bridge.sv | 263 ++++++++++++++++++++++++++
 tb/tb_axi4lite_burst_bridge.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_burst_bridge.sv
// AXI4 burst slave to AXI4-Lite master bridge, one Lite beat in flight per direction.
// Define AXI4LITE_BRIDGE_BRESP_MERGE_EN to report the worst bresp of a burst instead of the last one.
module axi4lite_burst_bridge #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,

  input  logic                inport_awvalid_i,
  output logic                inport_awready_o,
  input  logic [ADDR_W-1:0]   inport_awaddr_i,
  input  logic [ID_W-1:0]     inport_awid_i,
  input  logic [7:0]          inport_awlen_i,
  input  logic [1:0]          inport_awburst_i,

  input  logic                inport_wvalid_i,
  output logic                inport_wready_o,
  input  logic [DATA_W-1:0]   inport_wdata_i,
  input  logic [DATA_W/8-1:0] inport_wstrb_i,
  input  logic                inport_wlast_i,

  output logic                inport_bvalid_o,
  input  logic                inport_bready_i,
  output logic [1:0]          inport_bresp_o,
  output logic [ID_W-1:0]     inport_bid_o,

  input  logic                inport_arvalid_i,
  output logic                inport_arready_o,
  input  logic [ADDR_W-1:0]   inport_araddr_i,
  input  logic [ID_W-1:0]     inport_arid_i,
  input  logic [7:0]          inport_arlen_i,
  input  logic [1:0]          inport_arburst_i,

  output logic                inport_rvalid_o,
  input  logic                inport_rready_i,
  output logic [DATA_W-1:0]   inport_rdata_o,
  output logic [1:0]          inport_rresp_o,
  output logic [ID_W-1:0]     inport_rid_o,
  output logic                inport_rlast_o,

  output logic                outport_awvalid_o,
  input  logic                outport_awready_i,
  output logic [ADDR_W-1:0]   outport_awaddr_o,
  output logic                outport_wvalid_o,
  input  logic                outport_wready_i,
  output logic [DATA_W-1:0]   outport_wdata_o,
  output logic [DATA_W/8-1:0] outport_wstrb_o,
  input  logic                outport_bvalid_i,
  output logic                outport_bready_o,
  input  logic [1:0]          outport_bresp_i,

  output logic                outport_arvalid_o,
  input  logic                outport_arready_i,
  output logic [ADDR_W-1:0]   outport_araddr_o,
  input  logic                outport_rvalid_i,
  output logic                outport_rready_o,
  input  logic [DATA_W-1:0]   outport_rdata_i,
  input  logic [1:0]          outport_rresp_i
);

  localparam int STEP   = DATA_W / 8;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {W_IDLE, W_DATA, W_ISSUE, W_BRESP, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  // WRAP only wraps for power-of-two burst lengths; any other length behaves as INCR.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [1:0] burst,
                                                  input logic [7:0] len);
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] mask;
    incr = addr + ADDR_W'(STEP);
    mask = ((ADDR_W'(len) + ADDR_W'(1)) * ADDR_W'(STEP)) - ADDR_W'(1);
    if (burst == 2'd0)
      next_addr = addr;
    else if (burst == 2'd2 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
      next_addr = (addr & ~mask) | (incr & mask);
    else
      next_addr = incr;
  endfunction

  w_state_t            w_state;
  logic [ADDR_W-1:0]   aw_addr;
  logic [ID_W-1:0]     aw_id;
  logic [7:0]          aw_len;
  logic [1:0]          aw_burst;
  logic [7:0]          w_count;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                awready_q;
  logic                wready_q;
  logic                lite_awvalid_q;
  logic                lite_wvalid_q;
  logic                lite_bready_q;
  logic                bvalid_q;
  logic [1:0]          bresp_q;
  logic                aw_fin;
  logic                w_fin;

  r_state_t            r_state;
  logic [ADDR_W-1:0]   ar_addr;
  logic [ID_W-1:0]     ar_id;
  logic [7:0]          ar_len;
  logic [1:0]          ar_burst;
  logic [7:0]          r_count;
  logic                arready_q;
  logic                lite_arvalid_q;
  logic                r_last;

  // Burst end is taken from the beat counter, so wlast is deliberately not consulted.
  logic unused_wlast;
  assign unused_wlast = inport_wlast_i;

  assign aw_fin = !lite_awvalid_q || outport_awready_i;
  assign w_fin  = !lite_wvalid_q  || outport_wready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state        <= W_IDLE;
      aw_addr        <= '0;
      aw_id          <= '0;
      aw_len         <= '0;
      aw_burst       <= '0;
      w_count        <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      awready_q      <= 1'b1;
      wready_q       <= 1'b0;
      lite_awvalid_q <= 1'b0;
      lite_wvalid_q  <= 1'b0;
      lite_bready_q  <= 1'b0;
      bvalid_q       <= 1'b0;
      bresp_q        <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (inport_awvalid_i) begin
          aw_addr   <= inport_awaddr_i;
          aw_id     <= inport_awid_i;
          aw_len    <= inport_awlen_i;
          aw_burst  <= inport_awburst_i;
          w_count   <= '0;
          awready_q <= 1'b0;
          wready_q  <= 1'b1;
`ifdef AXI4LITE_BRIDGE_BRESP_MERGE_EN
          bresp_q   <= '0;
`endif
          w_state   <= W_DATA;
        end
        W_DATA: if (inport_wvalid_i) begin
          wdata_q        <= inport_wdata_i;
          wstrb_q        <= inport_wstrb_i;
          wready_q       <= 1'b0;
          lite_awvalid_q <= 1'b1;
          lite_wvalid_q  <= 1'b1;
          w_state        <= W_ISSUE;
        end
        // AW and W retire independently; a finished channel stays low until the next beat.
        W_ISSUE: begin
          if (lite_awvalid_q && outport_awready_i) lite_awvalid_q <= 1'b0;
          if (lite_wvalid_q && outport_wready_i)   lite_wvalid_q  <= 1'b0;
          if (aw_fin && w_fin) begin
            lite_bready_q <= 1'b1;
            w_state       <= W_BRESP;
          end
        end
        W_BRESP: if (outport_bvalid_i) begin
          lite_bready_q <= 1'b0;
`ifdef AXI4LITE_BRIDGE_BRESP_MERGE_EN
          if (outport_bresp_i > bresp_q) bresp_q <= outport_bresp_i;
`else
          bresp_q <= outport_bresp_i;
`endif
          if (w_count == aw_len) begin
            bvalid_q <= 1'b1;
            w_state  <= W_RESP;
          end else begin
            aw_addr  <= next_addr(aw_addr, aw_burst, aw_len);
            w_count  <= w_count + 8'd1;
            wready_q <= 1'b1;
            w_state  <= W_DATA;
          end
        end
        W_RESP: if (inport_bready_i) begin
          bvalid_q  <= 1'b0;
          awready_q <= 1'b1;
          w_state   <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state        <= R_IDLE;
      ar_addr        <= '0;
      ar_id          <= '0;
      ar_len         <= '0;
      ar_burst       <= '0;
      r_count        <= '0;
      arready_q      <= 1'b1;
      lite_arvalid_q <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (inport_arvalid_i) begin
          ar_addr        <= inport_araddr_i;
          ar_id          <= inport_arid_i;
          ar_len         <= inport_arlen_i;
          ar_burst       <= inport_arburst_i;
          r_count        <= '0;
          arready_q      <= 1'b0;
          lite_arvalid_q <= 1'b1;
          r_state        <= R_ADDR;
        end
        R_ADDR: if (outport_arready_i) begin
          lite_arvalid_q <= 1'b0;
          r_state        <= R_DATA;
        end
        R_DATA: if (outport_rvalid_i && inport_rready_i) begin
          if (r_last) begin
            arready_q <= 1'b1;
            r_state   <= R_IDLE;
          end else begin
            ar_addr        <= next_addr(ar_addr, ar_burst, ar_len);
            r_count        <= r_count + 8'd1;
            lite_arvalid_q <= 1'b1;
            r_state        <= R_ADDR;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign r_last = (r_count == ar_len);

  assign inport_awready_o  = awready_q;
  assign inport_wready_o   = wready_q;
  assign inport_bvalid_o   = bvalid_q;
  assign inport_bresp_o    = bresp_q;
  assign inport_bid_o      = aw_id;
  assign outport_awvalid_o = lite_awvalid_q;
  assign outport_awaddr_o  = aw_addr;
  assign outport_wvalid_o  = lite_wvalid_q;
  assign outport_wdata_o   = wdata_q;
  assign outport_wstrb_o   = wstrb_q;
  assign outport_bready_o  = lite_bready_q;

  // Read data is a straight passthrough while a beat is outstanding on the Lite side.
  assign inport_arready_o  = arready_q;
  assign outport_arvalid_o = lite_arvalid_q;
  assign outport_araddr_o  = ar_addr;
  assign inport_rvalid_o   = (r_state == R_DATA) && outport_rvalid_i;
  assign outport_rready_o  = (r_state == R_DATA) && inport_rready_i;
  assign inport_rdata_o    = outport_rdata_i;
  assign inport_rresp_o    = outport_rresp_i;
  assign inport_rid_o      = ar_id;
  assign inport_rlast_o    = r_last;

endmodule

// File: tb/tb_axi4lite_burst_bridge.sv
// Bench for axi4lite_burst_bridge: directed bursts against a Lite slave model, with a scoreboard
// monitor comparing every handshake on the Lite side and the AXI4 response side.
`timescale 1ns/1ps
module tb_axi4lite_burst_bridge;

`ifdef AXI4LITE_BRIDGE_BRESP_MERGE_EN
  localparam logic [1:0] MERGE_RESP = 2'd2;
`else
  localparam logic [1:0] MERGE_RESP = 2'd0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        inport_awvalid_i, inport_awready_o;
  logic [31:0] inport_awaddr_i;
  logic [3:0]  inport_awid_i;
  logic [7:0]  inport_awlen_i;
  logic [1:0]  inport_awburst_i;
  logic        inport_wvalid_i, inport_wready_o;
  logic [31:0] inport_wdata_i;
  logic [3:0]  inport_wstrb_i;
  logic        inport_wlast_i;
  logic        inport_bvalid_o, inport_bready_i;
  logic [1:0]  inport_bresp_o;
  logic [3:0]  inport_bid_o;
  logic        inport_arvalid_i, inport_arready_o;
  logic [31:0] inport_araddr_i;
  logic [3:0]  inport_arid_i;
  logic [7:0]  inport_arlen_i;
  logic [1:0]  inport_arburst_i;
  logic        inport_rvalid_o, inport_rready_i;
  logic [31:0] inport_rdata_o;
  logic [1:0]  inport_rresp_o;
  logic [3:0]  inport_rid_o;
  logic        inport_rlast_o;
  logic        outport_awvalid_o, outport_awready_i;
  logic [31:0] outport_awaddr_o;
  logic        outport_wvalid_o, outport_wready_i;
  logic [31:0] outport_wdata_o;
  logic [3:0]  outport_wstrb_o;
  logic        outport_bvalid_i, outport_bready_o;
  logic [1:0]  outport_bresp_i;
  logic        outport_arvalid_o, outport_arready_i;
  logic [31:0] outport_araddr_o;
  logic        outport_rvalid_i, outport_rready_o;
  logic [31:0] outport_rdata_i;
  logic [1:0]  outport_rresp_i;

  axi4lite_burst_bridge #(.DATA_W(32), .ADDR_W(32), .ID_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .inport_awvalid_i(inport_awvalid_i), .inport_awready_o(inport_awready_o),
    .inport_awaddr_i(inport_awaddr_i), .inport_awid_i(inport_awid_i),
    .inport_awlen_i(inport_awlen_i), .inport_awburst_i(inport_awburst_i),
    .inport_wvalid_i(inport_wvalid_i), .inport_wready_o(inport_wready_o),
    .inport_wdata_i(inport_wdata_i), .inport_wstrb_i(inport_wstrb_i), .inport_wlast_i(inport_wlast_i),
    .inport_bvalid_o(inport_bvalid_o), .inport_bready_i(inport_bready_i),
    .inport_bresp_o(inport_bresp_o), .inport_bid_o(inport_bid_o),
    .inport_arvalid_i(inport_arvalid_i), .inport_arready_o(inport_arready_o),
    .inport_araddr_i(inport_araddr_i), .inport_arid_i(inport_arid_i),
    .inport_arlen_i(inport_arlen_i), .inport_arburst_i(inport_arburst_i),
    .inport_rvalid_o(inport_rvalid_o), .inport_rready_i(inport_rready_i),
    .inport_rdata_o(inport_rdata_o), .inport_rresp_o(inport_rresp_o),
    .inport_rid_o(inport_rid_o), .inport_rlast_o(inport_rlast_o),
    .outport_awvalid_o(outport_awvalid_o), .outport_awready_i(outport_awready_i),
    .outport_awaddr_o(outport_awaddr_o),
    .outport_wvalid_o(outport_wvalid_o), .outport_wready_i(outport_wready_i),
    .outport_wdata_o(outport_wdata_o), .outport_wstrb_o(outport_wstrb_o),
    .outport_bvalid_i(outport_bvalid_i), .outport_bready_o(outport_bready_o),
    .outport_bresp_i(outport_bresp_i),
    .outport_arvalid_o(outport_arvalid_o), .outport_arready_i(outport_arready_i),
    .outport_araddr_o(outport_araddr_o),
    .outport_rvalid_i(outport_rvalid_i), .outport_rready_o(outport_rready_o),
    .outport_rdata_i(outport_rdata_i), .outport_rresp_i(outport_rresp_i)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;
  int r_beats = 0;

  // Scoreboard queues: lite AW/AR addr, lite W {strb,data}, R {id,resp,last,data}, B {id,resp}.
  logic [63:0] exp_aw[$];
  logic [63:0] exp_w[$];
  logic [63:0] exp_ar[$];
  logic [63:0] exp_r[$];
  logic [63:0] exp_b[$];

  int          aw_delay = 0;
  int          w_delay  = 0;
  logic [1:0]  bresp_plan[$];
  logic [31:0] rq[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic scoreTx(input string name, input int qsize, input logic [63:0] exp, input logic [63:0] act);
    if (qsize == 0) begin
      n_vec++;
      n_err++;
      $display("[TB] FAIL %s: got unexpected transfer 0x%0h, required none", name, act);
    end else begin
      checkOutput(name, act, exp);
    end
  endtask

  task automatic failTimeout(input string name);
    n_vec++;
    n_err++;
    $display("[TB] FAIL %s: got timeout, required completion", name);
  endtask

  function automatic logic [31:0] slaveData(input logic [31:0] addr);
    return addr ^ 32'hA5A5_0000;
  endfunction

  // Monitor: every handshake seen half a cycle ahead of the edge that completes it.
  initial begin
    logic [63:0] e;
    int qs;
    forever begin
      @(negedge clk_i);
      #1;
      if (!rst_i) begin
        if (outport_awvalid_o && outport_awready_i) begin
          qs = exp_aw.size(); e = '0;
          if (qs != 0) e = exp_aw.pop_front();
          scoreTx("lite_aw", qs, e, 64'(outport_awaddr_o));
        end
        if (outport_wvalid_o && outport_wready_i) begin
          qs = exp_w.size(); e = '0;
          if (qs != 0) e = exp_w.pop_front();
          scoreTx("lite_w", qs, e, 64'({outport_wstrb_o, outport_wdata_o}));
        end
        if (outport_arvalid_o && outport_arready_i) begin
          qs = exp_ar.size(); e = '0;
          if (qs != 0) e = exp_ar.pop_front();
          scoreTx("lite_ar", qs, e, 64'(outport_araddr_o));
        end
        if (inport_rvalid_o && inport_rready_i) begin
          qs = exp_r.size(); e = '0;
          if (qs != 0) e = exp_r.pop_front();
          scoreTx("axi_r", qs, e, 64'({inport_rid_o, inport_rresp_o, inport_rlast_o, inport_rdata_o}));
          r_beats++;
        end
        if (inport_bvalid_o && inport_bready_i) begin
          qs = exp_b.size(); e = '0;
          if (qs != 0) e = exp_b.pop_front();
          scoreTx("axi_b", qs, e, 64'({inport_bid_o, inport_bresp_o}));
        end
      end
    end
  end

  // Lite slave model: programmable AW/W ready delays, B after both accepted, R after AR.
  initial begin
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    int aw_wait, w_wait, aw_acc, w_acc, b_issued;
    logic [31:0] ar_hs_addr;
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
    aw_wait = 0; w_wait = 0; aw_acc = 0; w_acc = 0; b_issued = 0; ar_hs_addr = '0;
    outport_awready_i = 0; outport_wready_i = 0; outport_bvalid_i = 0; outport_bresp_i = 0;
    outport_arready_i = 0; outport_rvalid_i = 0; outport_rdata_i = 0; outport_rresp_i = 0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        outport_awready_i = 0; outport_wready_i = 0; outport_bvalid_i = 0;
        outport_arready_i = 0; outport_rvalid_i = 0;
        aw_wait = 0; w_wait = 0; aw_acc = 0; w_acc = 0; b_issued = 0;
        rq.delete();
      end else begin
        if (aw_hs) begin
          outport_awready_i = 0; aw_wait = 0; aw_acc++;
        end else if (outport_awvalid_o && !outport_awready_i) begin
          if (aw_wait >= aw_delay) outport_awready_i = 1; else aw_wait++;
        end
        if (w_hs) begin
          outport_wready_i = 0; w_wait = 0; w_acc++;
        end else if (outport_wvalid_o && !outport_wready_i) begin
          if (w_wait >= w_delay) outport_wready_i = 1; else w_wait++;
        end
        if (b_hs) outport_bvalid_i = 0;
        if (!outport_bvalid_i && b_issued < aw_acc && b_issued < w_acc) begin
          outport_bvalid_i = 1;
          outport_bresp_i = (bresp_plan.size() != 0) ? bresp_plan.pop_front() : 2'd0;
          b_issued++;
        end
        if (ar_hs) begin
          outport_arready_i = 0; rq.push_back(ar_hs_addr);
        end else if (outport_arvalid_o && !outport_arready_i) begin
          outport_arready_i = 1;
        end
        if (r_hs) outport_rvalid_i = 0;
        if (!outport_rvalid_i && rq.size() != 0) begin
          outport_rvalid_i = 1;
          outport_rdata_i = slaveData(rq.pop_front());
        end
      end
      #1;
      aw_hs = outport_awvalid_o && outport_awready_i;
      w_hs  = outport_wvalid_o && outport_wready_i;
      b_hs  = outport_bvalid_i && outport_bready_o;
      ar_hs = outport_arvalid_o && outport_arready_i;
      r_hs  = outport_rvalid_i && outport_rready_o;
      ar_hs_addr = outport_araddr_o;
    end
  end

  task automatic waitReady(input int sel, input string name);
    bit ok;
    ok = 0;
    for (int c = 0; c < 200 && !ok; c++) begin
      #1;
      if ((sel == 0 && inport_awready_o) || (sel == 1 && inport_wready_o) || (sel == 2 && inport_arready_o))
        ok = 1;
      else
        @(negedge clk_i);
    end
    if (!ok) failTimeout(name);
    @(negedge clk_i);
  endtask

  task automatic applyRead(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len, input logic [1:0] burst);
    @(negedge clk_i);
    inport_arvalid_i = 1; inport_araddr_i = addr; inport_arid_i = id;
    inport_arlen_i = len; inport_arburst_i = burst;
    waitReady(2, "ar_accept");
    inport_arvalid_i = 0;
  endtask

  task automatic applyWrite(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [1:0] burst, input logic [31:0] base);
    logic [3:0] strb;
    @(negedge clk_i);
    inport_awvalid_i = 1; inport_awaddr_i = addr; inport_awid_i = id;
    inport_awlen_i = len; inport_awburst_i = burst;
    waitReady(0, "aw_accept");
    inport_awvalid_i = 0;
    for (int b = 0; b <= int'(len); b++) begin
      strb = ~4'(b);
      exp_w.push_back(64'({strb, base + 32'(b)}));
      inport_wvalid_i = 1; inport_wdata_i = base + 32'(b); inport_wstrb_i = strb;
      inport_wlast_i = (b == int'(len));
      waitReady(1, "w_accept");
      inport_wvalid_i = 0;
    end
  endtask

  task automatic waitDrain(input string name, input int limit);
    int c;
    int pending;
    c = 0;
    while ((exp_aw.size() + exp_w.size() + exp_ar.size() + exp_r.size() + exp_b.size()) != 0 && c < limit) begin
      @(negedge clk_i);
      c++;
    end
    repeat (4) @(negedge clk_i);
    pending = exp_aw.size() + exp_w.size() + exp_ar.size() + exp_r.size() + exp_b.size();
    checkOutput(name, 64'(pending), 64'd0);
  endtask

  task automatic pushRead(input logic [31:0] addr, input logic [3:0] id, input bit last);
    exp_ar.push_back(64'(addr));
    exp_r.push_back(64'({id, 2'd0, last, slaveData(addr)}));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    int base;
    inport_awvalid_i = 0; inport_awaddr_i = 0; inport_awid_i = 0; inport_awlen_i = 0; inport_awburst_i = 0;
    inport_wvalid_i = 0; inport_wdata_i = 0; inport_wstrb_i = 0; inport_wlast_i = 0;
    inport_arvalid_i = 0; inport_araddr_i = 0; inport_arid_i = 0; inport_arlen_i = 0; inport_arburst_i = 0;
    inport_bready_i = 1; inport_rready_i = 1;
    repeat (3) @(negedge clk_i);
    #1;
    checkOutput("rst_awready", 64'(inport_awready_o), 64'd1);
    checkOutput("rst_arready", 64'(inport_arready_o), 64'd1);
    checkOutput("rst_valids", 64'({outport_awvalid_o, outport_wvalid_o, outport_arvalid_o, outport_bready_o,
                                   outport_rready_o, inport_bvalid_o, inport_rvalid_o, inport_wready_o}), 64'd0);
    checkOutput("rst_rlast", 64'(inport_rlast_o), 64'd1);
    checkOutput("rst_regs", 64'({outport_awaddr_o, outport_araddr_o}), 64'd0);
    checkOutput("rst_wdata_bid", 64'({outport_wdata_o, inport_bid_o, inport_rid_o}), 64'd0);
    @(negedge clk_i);
    rst_i = 0;

    // INCR read of four beats.
    pushRead(32'h1000, 4'd5, 0); pushRead(32'h1004, 4'd5, 0);
    pushRead(32'h1008, 4'd5, 0); pushRead(32'h100C, 4'd5, 1);
    applyRead(32'h1000, 4'd5, 8'd3, 2'd1);
    waitDrain("incr_read_done", 200);

    // WRAP write wrapping at the 16-byte boundary.
    exp_aw.push_back(64'h2008); exp_aw.push_back(64'h200C);
    exp_aw.push_back(64'h2000); exp_aw.push_back(64'h2004);
    exp_b.push_back(64'({4'd3, 2'd0}));
    applyWrite(32'h2008, 4'd3, 8'd3, 2'd2, 32'h1111_0000);
    waitDrain("wrap_write_done", 200);

    // Lite AW late, then Lite W late: one Lite transaction per beat.
    aw_delay = 2; w_delay = 0;
    exp_aw.push_back(64'h4000); exp_aw.push_back(64'h4004);
    exp_b.push_back(64'({4'd1, 2'd0}));
    applyWrite(32'h4000, 4'd1, 8'd1, 2'd1, 32'h2222_0000);
    waitDrain("aw_late_done", 200);
    aw_delay = 0; w_delay = 2;
    exp_aw.push_back(64'h5000); exp_aw.push_back(64'h5004);
    exp_b.push_back(64'({4'd2, 2'd0}));
    applyWrite(32'h5000, 4'd2, 8'd1, 2'd1, 32'h3333_0000);
    waitDrain("w_late_done", 200);
    w_delay = 0;

    // SLVERR on the second beat only.
    bresp_plan.push_back(2'd0); bresp_plan.push_back(2'd2);
    bresp_plan.push_back(2'd0); bresp_plan.push_back(2'd0);
    exp_aw.push_back(64'h6000); exp_aw.push_back(64'h6004);
    exp_aw.push_back(64'h6008); exp_aw.push_back(64'h600C);
    exp_b.push_back(64'({4'd7, MERGE_RESP}));
    applyWrite(32'h6000, 4'd7, 8'd3, 2'd1, 32'h4444_0000);
    waitDrain("merge_done", 200);

    // FIXED read with the master stalling R for five cycles.
    inport_rready_i = 0;
    pushRead(32'h3000, 4'd9, 0); pushRead(32'h3000, 4'd9, 1);
    applyRead(32'h3000, 4'd9, 8'd1, 2'd0);
    ok = 0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk_i); #1;
      if (inport_rvalid_o) ok = 1;
    end
    if (!ok) failTimeout("r_hold_rvalid");
    repeat (5) begin
      @(negedge clk_i); #1;
      checkOutput("r_hold_stable", 64'({inport_rvalid_o, inport_rlast_o, inport_rid_o, inport_rdata_o}),
                  64'({1'b1, 1'b0, 4'd9, 32'hA5A5_3000}));
    end
    @(negedge clk_i);
    inport_rready_i = 1;
    waitDrain("fixed_read_done", 200);

    // Concurrent write and long read, reset in the middle of the read.
    base = r_beats;
    for (int i = 0; i < 8; i++) pushRead(32'h7000 + 32'(4 * i), 4'd6, i == 7);
    exp_aw.push_back(64'h8000);
    exp_b.push_back(64'({4'd4, 2'd0}));
    fork
      applyWrite(32'h8000, 4'd4, 8'd0, 2'd1, 32'h5555_0000);
      applyRead(32'h7000, 4'd6, 8'd7, 2'd1);
    join
    ok = 0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk_i);
      if (exp_b.size() == 0 && r_beats >= base + 3) ok = 1;
    end
    if (!ok) failTimeout("concurrent_progress");
    @(negedge clk_i);
    rst_i = 1;
    exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_r.delete(); exp_b.delete();
    bresp_plan.delete();
    #1;
    checkOutput("midrst_readies", 64'({inport_awready_o, inport_arready_o}), 64'd3);
    checkOutput("midrst_valids", 64'({outport_awvalid_o, outport_wvalid_o, outport_arvalid_o,
                                      inport_bvalid_o, inport_rvalid_o, outport_rready_o}), 64'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 0;

    pushRead(32'h9000, 4'd1, 1);
    exp_aw.push_back(64'hA000);
    exp_b.push_back(64'({4'd2, 2'd0}));
    fork
      applyRead(32'h9000, 4'd1, 8'd0, 2'd1);
      applyWrite(32'hA000, 4'd2, 8'd0, 2'd1, 32'h6666_0000);
    join
    waitDrain("post_reset_done", 200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
